// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared op codes, FSM states, peripheral map and load helpers
package mem_access_unit_pkg;

    // CPU request op encodings; anything above OP_SB is illegal
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_SW  = 3'd3;
    localparam logic [2:0] OP_SB  = 3'd4;

    // Memory-mapped peripheral registers reachable through word accesses
    localparam logic [31:0] PERIPH_ADDR_0C = 32'h4000_000C;
    localparam logic [31:0] PERIPH_ADDR_10 = 32'h4000_0010;
    localparam logic [31:0] PERIPH_ADDR_14 = 32'h4000_0014;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_DONE
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_SB);
    endfunction

    function automatic logic op_is_byte(input logic [2:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

    // Byte reads return the selected byte in [7:0]; widen it per the load flavour
    function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [31:0] rdata);
        logic [31:0] result;
        case (op)
            OP_LB:   result = {{24{rdata[7]}}, rdata[7:0]};
            OP_LBU:  result = {24'h0, rdata[7:0]};
            default: result = rdata;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// rtl/byte_lane_merge.sv - big-endian byte lane insert into a captured word
module byte_lane_merge (
    input  logic [31:0] word_i,
    input  logic [7:0]  byte_i,
    input  logic [1:0]  tail_i,
    output logic [31:0] word_o
);

    // Replace only the addressed lane; tail 00 is the most significant byte
    always_comb begin
        word_o = word_i;
        case (tail_i)
            2'b00:   word_o[31:24] = byte_i;
            2'b01:   word_o[23:16] = byte_i;
            2'b10:   word_o[15:8]  = byte_i;
            default: word_o[7:0]   = byte_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU load/store sequencer onto a single-cycle memory bus
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        LwLb,
    output logic [31:0] addr,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    state_e      state_q;
    logic [2:0]  op_q;
    logic [1:0]  tail_q;
    logic [7:0]  byte_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        lw_lb_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        req_err;
    logic        word_misaligned;
    logic        byte_out_of_range;
    logic [31:0] merged_word;

    // Reject decode evaluated on the live request at the accept edge
    always_comb begin
        word_misaligned   = ((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00);
        byte_out_of_range = op_is_byte(req_op) && ({2'b00, req_addr[31:2]} >= MEM_WORDS_W);
        req_err           = !op_is_legal(req_op) || word_misaligned || byte_out_of_range;
    end

    // Read data arrives during RMW_RD, so the merge sees it the same cycle it is captured
    byte_lane_merge u_merge (
        .word_i (ReadData),
        .byte_i (byte_q),
        .tail_i (tail_q),
        .word_o (merged_word)
    );

    // Request sequencer; every output is registered and set up one state ahead
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LW;
            tail_q      <= 2'b00;
            byte_q      <= 8'h00;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            lw_lb_q     <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        tail_q      <= req_addr[1:0];
                        byte_q      <= req_wdata[7:0];
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            state_q     <= ST_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= 32'h0;
                        end else if (req_op == OP_SW) begin
                            state_q     <= ST_WR;
                            mem_write_q <= 1'b1;
                            addr_q      <= req_addr;
                            wdata_q     <= req_wdata;
                        end else if (req_op == OP_SB) begin
                            state_q    <= ST_RMW_RD;
                            mem_read_q <= 1'b1;
                            lw_lb_q    <= 1'b0;
                            addr_q     <= {req_addr[31:2], 2'b00};
                        end else begin
                            state_q    <= ST_RD;
                            mem_read_q <= 1'b1;
                            lw_lb_q    <= (req_op != OP_LW);
                            addr_q     <= req_addr;
                        end
                    end
                end
                ST_RD: begin
                    state_q     <= ST_DONE;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= load_extend(op_q, ReadData);
                    mem_read_q  <= 1'b0;
                    lw_lb_q     <= 1'b0;
                    addr_q      <= 32'h0;
                end
                ST_WR: begin
                    state_q     <= ST_DONE;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= 32'h0;
                    mem_write_q <= 1'b0;
                    addr_q      <= 32'h0;
                    wdata_q     <= 32'h0;
                end
                ST_RMW_RD: begin
                    // Read strobe drops before write rises, keeping the two exclusive
                    state_q     <= ST_RMW_WR;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b1;
                    wdata_q     <= merged_word;
                end
                ST_RMW_WR: begin
                    state_q     <= ST_DONE;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= 32'h0;
                    mem_write_q <= 1'b0;
                    addr_q      <= 32'h0;
                    wdata_q     <= 32'h0;
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= 32'h0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= 32'h0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    lw_lb_q     <= 1'b0;
                    addr_q      <= 32'h0;
                    wdata_q     <= 32'h0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign MemRead   = mem_read_q;
    assign MemWrite  = mem_write_q;
    assign LwLb      = lw_lb_q;
    assign addr      = addr_q;
    assign WriteData = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        MemRead;
    logic        MemWrite;
    logic        LwLb;
    logic [31:0] addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    mem_access_unit #(.MEM_WORDS(512)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .LwLb      (LwLb),
        .addr      (addr),
        .WriteData (WriteData),
        .ReadData  (ReadData)
    );

    always #5 clk = ~clk;

    // Bus memory model: 512 words, big-endian byte lanes, writes commit at the edge
    logic [31:0] mem [0:511];
    logic [31:0] rd_word;

    function automatic logic [7:0] lane_of(input logic [31:0] w, input logic [1:0] t);
        case (t)
            2'b00:   return w[31:24];
            2'b01:   return w[23:16];
            2'b10:   return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    always_comb begin
        rd_word  = 32'h0;
        ReadData = 32'h0;
        if (MemRead && (addr[31:2] < 30'd512)) begin
            rd_word  = mem[addr[10:2]];
            ReadData = LwLb ? {24'h0, lane_of(rd_word, addr[1:0])} : rd_word;
        end
    end

    always @(posedge clk) begin
        if (MemWrite && (addr[31:2] < 30'd512))
            mem[addr[10:2]] <= WriteData;
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int n_pass = 0;
    int n_chk  = 0;

    int          rd_n, wr_n, both_n, rd_cyc, wr_cyc;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic        rd_lwlb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the inputs after accept, and score the response
    task automatic run_req(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_data,
                           input logic exp_err, input int exp_lat);
        exp_t e;
        int   k;
        logic got;
        sb.push_back('{data: exp_data, err: exp_err, lat: exp_lat});
        @(negedge clk);
        check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        check({tag, "_idle_rsp"}, {31'h0, rsp_valid}, 32'h0);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom_range(0, 4));
        req_addr  = $urandom;
        req_wdata = $urandom;
        rd_n = 0; wr_n = 0; both_n = 0; rd_cyc = 0; wr_cyc = 0;
        rd_addr = 32'h0; wr_addr = 32'h0; wr_data = 32'h0; rd_lwlb = 1'b0;
        got = 1'b0;
        k   = 0;
        while (!got && k < 8) begin
            k++;
            @(negedge clk);
            if (MemRead && MemWrite) both_n++;
            if (MemRead) begin
                rd_n++; rd_cyc = k; rd_addr = addr; rd_lwlb = LwLb;
            end
            if (MemWrite) begin
                wr_n++; wr_cyc = k; wr_addr = addr; wr_data = WriteData;
            end
            if (rsp_valid) got = 1'b1;
            else @(posedge clk);
        end
        e = sb.pop_front();
        check({tag, "_rsp_seen"}, {31'h0, rsp_valid}, 32'h1);
        if (got) begin
            check({tag, "_latency"}, k, e.lat);
            check({tag, "_data"}, rsp_data, e.data);
            check({tag, "_err"}, {31'h0, rsp_err}, {31'h0, e.err});
            check({tag, "_bus_idle_done"}, addr | WriteData | {29'h0, MemRead, MemWrite, LwLb}, 32'h0);
        end
        check({tag, "_rd_wr_excl"}, both_n, 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_outs", {28'h0, rsp_valid, rsp_err, MemRead, MemWrite}, 32'h0);
        check("rst_addr", addr | WriteData | rsp_data, 32'h0);
        reset = 1'b0;

        run_req("sw10", 3'd3, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 2);
        check("sw10_wr_cyc", wr_cyc, 1);
        check("sw10_wr_n", wr_n, 1);
        check("sw10_wr_addr", wr_addr, 32'h10);
        check("sw10_wr_data", wr_data, 32'h1122_3344);
        check("sw10_rd_n", rd_n, 0);

        run_req("lw10", 3'd0, 32'h10, 32'hDEAD_BEEF, 32'h1122_3344, 1'b0, 2);
        check("lw10_rd_cyc", rd_cyc, 1);
        check("lw10_rd_addr", rd_addr, 32'h10);
        check("lw10_lwlb", {31'h0, rd_lwlb}, 32'h0);

        run_req("sb11", 3'd4, 32'h11, 32'h1234_56AA, 32'h0, 1'b0, 3);
        check("sb11_rd_cyc", rd_cyc, 1);
        check("sb11_rd_addr", rd_addr, 32'h10);
        check("sb11_wr_cyc", wr_cyc, 2);
        check("sb11_wr_addr", wr_addr, 32'h10);
        check("sb11_wr_data", wr_data, 32'h11AA_3344);

        run_req("lb11", 3'd1, 32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0, 2);
        check("lb11_lwlb", {31'h0, rd_lwlb}, 32'h1);
        check("lb11_rd_addr", rd_addr, 32'h11);
        run_req("lbu11", 3'd2, 32'h11, 32'h0, 32'h0000_00AA, 1'b0, 2);
        run_req("lb13", 3'd1, 32'h13, 32'h0, 32'h0000_0044, 1'b0, 2);
        run_req("lb10", 3'd1, 32'h10, 32'h0, 32'h0000_0011, 1'b0, 2);

        run_req("lw12", 3'd0, 32'h12, 32'h0, 32'h0, 1'b1, 1);
        check("lw12_rd_n", rd_n, 0);
        run_req("sw_mis", 3'd3, 32'h13, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
        check("sw_mis_wr_n", wr_n, 0);
        run_req("sb800", 3'd4, 32'h800, 32'h77, 32'h0, 1'b1, 1);
        check("sb800_wr_n", wr_n, 0);
        check("sb800_rd_n", rd_n, 0);
        run_req("lbu800", 3'd2, 32'h801, 32'h0, 32'h0, 1'b1, 1);
        run_req("illegal5", 3'd5, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        run_req("illegal7", 3'd7, 32'h10, 32'h0, 32'h0, 1'b1, 1);

        run_req("sb7ff", 3'd4, 32'h7FF, 32'h0000_005C, 32'h0, 1'b0, 3);
        check("sb7ff_wr_addr", wr_addr, 32'h7FC);
        check("sb7ff_wr_data", wr_data, 32'h0000_005C);
        run_req("lbu7ff", 3'd2, 32'h7FF, 32'h0, 32'h0000_005C, 1'b0, 2);
        run_req("lw7fc", 3'd0, 32'h7FC, 32'h0, 32'h0000_005C, 1'b0, 2);

        run_req("sw_periph", 3'd3, 32'h4000_000C, 32'h0000_005A, 32'h0, 1'b0, 2);
        check("sw_periph_wr_n", wr_n, 1);
        check("sw_periph_addr", wr_addr, 32'h4000_000C);
        check("sw_periph_data", wr_data, 32'h0000_005A);

        // Reset while the SB read phase is on the bus must cancel the write
        begin
            int wr_seen;
            wr_seen = 0;
            @(negedge clk);
            req_valid = 1'b1;
            req_op    = 3'd4;
            req_addr  = 32'h21;
            req_wdata = 32'h0000_0099;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            @(negedge clk);
            check("rst_rmw_in_rd", {31'h0, MemRead}, 32'h1);
            if (MemWrite) wr_seen++;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            @(negedge clk);
            check("rst_rmw_ready", {31'h0, req_ready}, 32'h1);
            check("rst_rmw_outs", {29'h0, rsp_valid, MemRead, MemWrite}, 32'h0);
            for (int i = 0; i < 5; i++) begin
                if (MemWrite) wr_seen++;
                @(negedge clk);
            end
            check("rst_rmw_no_write", wr_seen, 0);
            check("rst_rmw_mem", mem[8], 32'h0);
        end

        run_req("lw_after_rst", 3'd0, 32'h10, 32'h0, 32'h11AA_3344, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
